// File: rtl/hps_flag_in_pkg.sv
// Shared constants for the HPS flag input port: register map and edge-type encodings.
package hps_flag_in_pkg;

    // Word addresses within the port
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge capture selection
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Edge detector shared by every bit; unknown selections fall back to rising
    function automatic logic detect_edge(input int unsigned edge_type, input logic cur,
                                         input logic prev);
        case (edge_type)
            EDGE_FALL: return ~cur & prev;
            EDGE_ANY:  return cur ^ prev;
            default:   return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/flag_sync_edge.sv
// One flag bit: two-flop synchronizer, delay flop and edge detector.
module flag_sync_edge
    import hps_flag_in_pkg::*;
#(
    parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic sync_out,
    output logic edge_hit
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronizer chain followed by the previous-value flop used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync_out = sync2;

    // Edge pulse is valid for the cycle in which sync2 and prev differ
    always_comb begin
        edge_hit = detect_edge(EDGE_TYPE, sync2, prev);
    end

endmodule

// File: rtl/hps_flag_in.sv
// Avalon-MM input port: synchronized fabric flags, sticky edge capture and masked interrupt.
module hps_flag_in
    import hps_flag_in_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_data;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] edge_cap_d;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & write_n;

    // Only the low WIDTH bits of a write are meaningful
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        flag_sync_edge #(
            .EDGE_TYPE (EDGE_TYPE)
        ) u_sync_edge (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .sync_out (sync_data[i]),
            .edge_hit (edge_det[i])
        );
    end

    // Register next-state: mask load, and capture where a new edge beats a same-cycle clear
    always_comb begin
        cap_clr    = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
    end

    // Read mux; unused upper bits and the reserved word read as zero
    always_comb begin
        rd_word = '0;
        unique case (address)
            ADDR_DATA:    rd_word[WIDTH-1:0] = sync_data;
            ADDR_RSVD:    rd_word = '0;
            ADDR_IRQMASK: rd_word[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: rd_word[WIDTH-1:0] = edge_cap_q;
        endcase
        readdata_d = rd_en ? rd_word : readdata_q;
    end

    // Register file and read-data holding register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    // Level interrupt straight from registers so mask and clear writes act at their edge
    always_comb begin
        irq = |(edge_cap_q & irq_mask_q);
    end

endmodule

// File: tb/tb_hps_flag_in.sv
// Bench for hps_flag_in: three 4-bit instances (rise/fall/any) on one bus, checked against a
// sample-history model, with directed steps followed by randomized traffic.
module tb_hps_flag_in;

    localparam int unsigned W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_a, in_b, in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int total = 0;
    int bad = 0;

    // Model: inputs seen at the last three edges (index 0 newest) and architectural registers
    logic [W-1:0] seen [3][3];
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask [3];
    logic [31:0]  m_rd [3];

    always #5 clk = ~clk;

    hps_flag_in #(.WIDTH(W), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a)
    );
    hps_flag_in #(.WIDTH(W), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b)
    );
    hps_flag_in #(.WIDTH(W), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c)
    );

    function automatic logic [W-1:0] edges_of(input int kind, input logic [W-1:0] now_v,
                                              input logic [W-1:0] old_v);
        case (kind)
            1:       return ~now_v & old_v;
            2:       return now_v ^ old_v;
            default: return now_v & ~old_v;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 3; d++) seen[k][d] = '0;
            m_cap[k]  = '0;
            m_mask[k] = '0;
            m_rd[k]   = '0;
        end
    endtask

    // One clock: snapshot bus and inputs, advance the model at the edge, compare 1 ns later
    task automatic tick();
        logic [W-1:0] ins [3];
        logic [W-1:0] hit;
        logic wr, rd, rst_at_edge;
        logic [1:0] a;
        logic [31:0] wd;
        ins[0] = in_a;
        ins[1] = in_b;
        ins[2] = in_c;
        wr = chipselect && !write_n;
        rd = chipselect && write_n;
        a  = address;
        wd = writedata;
        rst_at_edge = !reset_n;
        @(posedge clk);
        if (rst_at_edge) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rd) begin
                    case (a)
                        2'd0:    m_rd[k] = {28'b0, seen[k][1]};
                        2'd2:    m_rd[k] = {28'b0, m_mask[k]};
                        2'd3:    m_rd[k] = {28'b0, m_cap[k]};
                        default: m_rd[k] = 32'h0;
                    endcase
                end
                hit = edges_of(k, seen[k][1], seen[k][2]);
                if (wr && a == 2'd3) m_cap[k] = (m_cap[k] & ~wd[W-1:0]) | hit;
                else                 m_cap[k] = m_cap[k] | hit;
                if (wr && a == 2'd2) m_mask[k] = wd[W-1:0];
                seen[k][2] = seen[k][1];
                seen[k][1] = seen[k][0];
                seen[k][0] = ins[k];
            end
        end
        #1;
        check("rd_rise", rd_a, m_rd[0]);
        check("rd_fall", rd_b, m_rd[1]);
        check("rd_any",  rd_c, m_rd[2]);
        check("irq_rise", {31'b0, irq_a}, {31'b0, |(m_cap[0] & m_mask[0])});
        check("irq_fall", {31'b0, irq_b}, {31'b0, |(m_cap[1] & m_mask[1])});
        check("irq_any",  {31'b0, irq_c}, {31'b0, |(m_cap[2] & m_mask[2])});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        idle();
    endtask

    task automatic rd_reg(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        idle();
    endtask

    initial begin
        idle();
        in_a = '0;
        in_b = '0;
        in_c = '0;
        model_reset();
        ticks(2);
        reset_n = 1'b1;

        // Reset state
        rd_reg(2'd0);
        check("data_reset", rd_a, 32'h0);
        check("irq_reset", {31'b0, irq_a}, 32'h0);

        // Capture timing and masked irq
        in_a = 4'b0101;
        in_b = 4'b0001;
        in_c = 4'b0001;
        wr_reg(2'd2, 32'h1);
        tick();
        check("irq_k1", {31'b0, irq_a}, 32'h0);
        tick();
        check("irq_k2", {31'b0, irq_a}, 32'h1);
        rd_reg(2'd3);
        check("cap_rise", rd_a, 32'h5);
        check("cap_fall_norise", rd_b, 32'h0);
        check("cap_any_rise", rd_c, 32'h1);

        // W1C drops irq at the clearing edge
        wr_reg(2'd3, 32'h1);
        check("irq_cleared", {31'b0, irq_a}, 32'h0);
        rd_reg(2'd3);
        check("cap_after_w1c", rd_a, 32'h4);
        check("cap_any_w1c", rd_c, 32'h0);

        // Set beats clear on the same bit in the same cycle
        in_a = 4'b0001;
        ticks(3);
        wr_reg(2'd3, 32'h4);
        rd_reg(2'd3);
        check("cap_bit2_clear", rd_a, 32'h0);
        in_a = 4'b0101;
        ticks(2);
        wr_reg(2'd3, 32'h4);
        rd_reg(2'd3);
        check("set_wins", rd_a, 32'h4);

        // Falling and any-edge capture
        in_b = 4'b0000;
        in_c = 4'b0000;
        ticks(3);
        rd_reg(2'd3);
        check("cap_fall", rd_b, 32'h1);
        check("cap_any_fall", rd_c, 32'h1);

        // Asynchronous reset mid-cycle with captures pending
        in_a = 4'b0000;
        ticks(3);
        wr_reg(2'd3, 32'hF);
        in_a = 4'b0011;
        ticks(3);
        wr_reg(2'd2, 32'hF);
        rd_reg(2'd3);
        check("cap_pre_rst", rd_a, 32'h3);
        check("irq_pre_rst", {31'b0, irq_a}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("irq_async_rst", {31'b0, irq_a}, 32'h0);
        check("rd_async_rst", rd_a, 32'h0);
        model_reset();
        tick();
        reset_n = 1'b1;
        rd_reg(2'd3);
        check("cap_after_rst", rd_a, 32'h0);
        rd_reg(2'd2);
        check("mask_after_rst", rd_a, 32'h0);
        ticks(2);
        rd_reg(2'd3);
        check("cap_high_at_release", rd_a, 32'h3);

        // Writes to DATA and reserved are ignored
        wr_reg(2'd2, 32'h5);
        wr_reg(2'd0, 32'hFFFF_FFFF);
        wr_reg(2'd1, 32'hFFFF_FFFF);
        rd_reg(2'd1);
        check("rsvd_read", rd_a, 32'h0);
        rd_reg(2'd2);
        check("mask_kept", rd_a, 32'h5);
        rd_reg(2'd3);
        check("cap_kept", rd_a, 32'h3);

        // DATA read latency is exactly one edge
        in_a = 4'b1010;
        ticks(3);
        rd_reg(2'd1);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        #1;
        check("data_before_edge", rd_a, 32'h0);
        tick();
        idle();
        check("data_lat1", rd_a, 32'hA);

        // Randomized traffic
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(3) == 0) in_a = W'($urandom);
            if ($urandom_range(3) == 0) in_b = W'($urandom);
            if ($urandom_range(3) == 0) in_c = W'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            if ($urandom_range(199) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_rst", rd_a | rd_b | rd_c, 32'h0);
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hps_flag_in.md
# hps_flag_in

Avalon-MM slave input port returning fabric status flags (e.g. SHA3 core done/busy) to the HPS, the reverse direction of the HPS-to-fabric flag output. Each of WIDTH asynchronous fabric inputs is synchronized, readable as live data, and edge-captured into sticky bits. Captured edges raise an interrupt, gated by a per-bit mask, so software does not have to poll for hash completion. Sits on the lightweight HPS-to-FPGA bridge next to the flag output port.

## Interface
- WIDTH, 1: number of flag inputs, 1..32.
- EDGE_TYPE, 0: capture on 0 = rising, 1 = falling, 2 = any edge.
- clk  in  1  system clock; every register is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address within the port.
- chipselect  in  1  slave selected.
- write_n  in  1  active-low write strobe. A read is chipselect with write_n high.
- writedata  in  32  write data.
- readdata  out  32  registered read data. Bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous fabric flags.
- irq  out  1  level interrupt to the HPS.

## Operation
- Register map:
  - 0 DATA, read-only: synchronized in_port. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, RW, WIDTH bits.
  - 3 EDGECAP, read / write-1-to-clear.
- Synchronizer: two flops per bit (sync1, sync2), then a delay flop prev.
- Edge detect per bit:
  - rising = sync2 & ~prev.
  - falling = ~sync2 & prev.
  - any = sync2 ^ prev.
- EDGECAP bit sets on a detected edge and holds until software writes 1 to that bit.
- Set and clear of the same bit in the same cycle: set wins and the bit stays 1.
- Clearing one bit never affects other bits.
- IRQMASK write loads writedata[WIDTH-1:0].
- irq = OR over bits of (EDGECAP & IRQMASK). It is a combinational function of these registers only.
- Reset values: sync1, sync2, prev, IRQMASK, EDGECAP, readdata and irq are all 0.
  - An input already high when reset releases produces a rising edge and is captured.
  - Firmware clears EDGECAP after init; this behaviour is decided and not filtered.
- Reset asserted mid-operation clears everything immediately, including pending captures and irq.
- Writes to addresses 0 and 1 have no effect.
- Reads have no side effects, including reads of EDGECAP.

## Timing
- Read latency 1:
  - Read issued in cycle n (chipselect=1, write_n=1).
  - readdata is valid after edge n+1 and holds until the next read.
  - No waitrequest.
- Write takes effect at the edge ending the write cycle; a read in the next cycle sees the new value.
- in_port change sampled by sync1 at edge k:
  - sync2 updates at k+1; DATA reflects the change for a read issued after k+1.
  - EDGECAP sets at k+2.
  - irq rises at k+2 if the bit is masked on.
- Pulses shorter than one clk period may be missed. Source pulses must be at least 2 clk wide.
- Unmasking a bit whose EDGECAP is already 1 raises irq at the edge that ends the IRQMASK write.
- Clearing EDGECAP drops irq at that same edge unless another masked bit is still set or the set-wins rule applies.

## Structure
- Shared package holds:
  - register address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module flag_sync_edge:
  - per-bit two-flop synchronizer plus prev flop and edge detector, parameterized by EDGE_TYPE.
  - instantiated WIDTH times via generate.
- Top level holds the register file, read mux and irq reduction.

## Test plan
- Reset, then read DATA with in_port=4'b0000 (WIDTH=4, EDGE_TYPE=0): readdata=0x0, irq=0; with IRQMASK=0 at reset, irq stays 0 at every cycle.
- Drive in_port=4'b0101, write IRQMASK=0x1:
  - EDGECAP reads 0x5 from k+2.
  - irq=1.
  - Write 0x1 to EDGECAP: it reads 0x4 and irq=0 at the next edge.
- Rising edge on bit 2 in the same cycle as a write of 0x4 to EDGECAP: EDGECAP bit 2 stays 1.
- With EDGE_TYPE=1, drive bit 0 from 1 to 0: EDGECAP reads 0x1. With EDGE_TYPE=2, drive 0 then 1 then 0 and clear between: capture occurs on both edges.
- Set EDGECAP=0x3 and IRQMASK=0xF, then pulse reset_n low mid-cycle:
  - irq, EDGECAP, IRQMASK and readdata clear asynchronously.
  - Writes to address 0 and address 1 change nothing; address 1 reads 0x0.
- Read of DATA: readdata is valid exactly one cycle after chipselect. Bits 31..WIDTH always read 0.
